// File: rtl/add_result_stage.sv
// ============================================================================
// Module   : add_result_stage
// Purpose  : 2-entry in-order result FIFO behind an adder, with a zero flag
//            per entry and a saturating count of accepted carry-out results.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module add_result_stage #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N:0]   tot_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] sum_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic         valid_o,
  input  logic         ready_i,
  input  logic         clr_cnt_i,
  output logic [7:0]   carry_cnt_o
);

  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  logic [N-1:0] r_sum   [2];
  logic         r_carry [2];
  logic         r_zero  [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic [7:0]   r_cnt;

  logic         w_push;
  logic         w_pop;

  // Readiness depends only on stored occupancy, so no ready_i -> ready_o path.
  assign ready_o = (r_occ < 2'd2) & ~rst_i;
  assign valid_o = (r_occ != 2'd0);
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;

  assign sum_o       = valid_o ? r_sum[r_rd_ptr]   : '0;
  assign carry_o     = valid_o ? r_carry[r_rd_ptr] : 1'b0;
  assign zero_o      = valid_o ? r_zero[r_rd_ptr]  : 1'b0;
  assign carry_cnt_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_sum[r_wr_ptr]   <= tot_i[N-1:0];
        r_carry[r_wr_ptr] <= tot_i[N];
        r_zero[r_wr_ptr]  <= (tot_i[N-1:0] == '0);
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Clear wins over a same-cycle carry push.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      r_cnt <= 8'd0;
    end else if (w_push && tot_i[N] && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_result_stage.sv
// ============================================================================
// Module   : tb_add_result_stage
// Purpose  : Self-checking bench for add_result_stage against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_add_result_stage;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N:0]   tot;
  logic         valid_in;
  logic         ready_out;
  logic [N-1:0] sum;
  logic         carry;
  logic         zero;
  logic         valid_out;
  logic         ready_in;
  logic         clr;
  logic [7:0]   cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: a plain queue of captured totals and an integer counter.
  logic [N:0] q[$];
  int         m_cnt = 0;

  add_result_stage #(.N(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tot_i      (tot),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
    .sum_o      (sum),
    .carry_o    (carry),
    .zero_o     (zero),
    .valid_o    (valid_out),
    .ready_i    (ready_in),
    .clr_cnt_i  (clr),
    .carry_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    logic [N:0] head;
    logic       has;
    has  = (q.size() != 0);
    head = has ? q[0] : '0;
    chk({ctx, ".ready"}, 32'(ready_out), 32'((q.size() < 2) && !rst));
    chk({ctx, ".valid"}, 32'(valid_out), 32'(has));
    chk({ctx, ".sum"},   32'(sum),       32'(head[N-1:0]));
    chk({ctx, ".carry"}, 32'(carry),     32'(head[N]));
    chk({ctx, ".zero"},  32'(zero),      32'(has && (head[N-1:0] == 0)));
    chk({ctx, ".cnt"},   32'(cnt),       32'(m_cnt));
  endtask

  task automatic model_edge();
    logic do_push, do_pop;
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      do_push = valid_in && (q.size() < 2);
      do_pop  = ready_in && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(tot);
      if (clr) m_cnt = 0;
      else if (do_push && tot[N] && m_cnt < 255) m_cnt++;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model at the edge.
  task automatic cycle(input string ctx, input logic r, input logic v,
                       input logic [N:0] t, input logic rd, input logic c);
    rst = r; valid_in = v; tot = t; ready_in = rd; clr = c;
    @(negedge clk);
    check_all(ctx);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; tot = '0; ready_in = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    model_edge();
    cycle("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle("post_reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Basic capture and zero flag.
    cycle("cap_push", 1'b0, 1'b1, 5'b1_0011, 1'b1, 1'b0);
    cycle("cap_out", 1'b0, 1'b1, 5'b1_0000, 1'b1, 1'b0);
    cycle("zero_out", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("drained", 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B accepted, C refused, then drain.
    cycle("bp_a", 1'b0, 1'b1, 5'h01, 1'b0, 1'b0);
    cycle("bp_b", 1'b0, 1'b1, 5'h02, 1'b0, 1'b0);
    cycle("bp_c", 1'b0, 1'b1, 5'h03, 1'b0, 1'b0);
    cycle("bp_hold", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle("bp_pop_a", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("bp_pop_b", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("bp_empty", 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Streaming: push and pop every cycle, occupancy stays at 1.
    for (int i = 0; i < 10; i++)
      cycle("stream", 1'b0, 1'b1, 5'(i * 3 + 1), 1'b1, 1'b0);
    cycle("stream_tail", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("stream_end", 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Saturation, then clear racing a carry push.
    for (int i = 0; i < 300; i++)
      cycle("sat", 1'b0, 1'b1, {1'b1, 4'($urandom)}, 1'b1, 1'b0);
    cycle("sat_done", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("clr_push", 1'b0, 1'b1, 5'b1_0101, 1'b1, 1'b1);
    cycle("clr_after", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("clr_idle", 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset while full, with a push attempted during reset.
    cycle("full_a", 1'b0, 1'b1, 5'h1A, 1'b0, 1'b0);
    cycle("full_b", 1'b0, 1'b1, 5'h0B, 1'b0, 1'b0);
    cycle("full_rst", 1'b1, 1'b1, 5'h1C, 1'b0, 1'b0);
    cycle("after_rst", 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      cycle("rand", ($urandom_range(0, 59) == 0), 1'($urandom), 5'($urandom),
            1'($urandom), ($urandom_range(0, 29) == 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/add_result_stage.md
ADD_RESULT_STAGE -- requirements
Module: add_result_stage

Interface
REQ-001 SHALL have parameter N, default 4, giving the sum width in bits of the upstream adder.
REQ-002 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port tot_i, input, N+1 bits, the adder total {carry, sum}, with carry in bit N.
REQ-005 SHALL have port valid_i, input, 1 bit, meaning tot_i holds a result to capture.
REQ-006 SHALL have port ready_o, output, 1 bit, meaning the stage can accept a result this cycle.
REQ-007 SHALL have port sum_o, output, N bits, the sum field of the head entry.
REQ-008 SHALL have port carry_o, output, 1 bit, the carry of the head entry.
REQ-009 SHALL have port zero_o, output, 1 bit, set when the head entry's sum field is all zeros.
REQ-010 SHALL have port valid_o, output, 1 bit, meaning a head entry is present.
REQ-011 SHALL have port ready_i, input, 1 bit, meaning the downstream consumer takes the head entry.
REQ-012 SHALL have port clr_cnt_i, input, 1 bit, a synchronous clear of carry_cnt_o.
REQ-013 SHALL have port carry_cnt_o, output, 8 bits, a saturating count of accepted entries whose carry bit is 1.

Function
REQ-014 SHALL implement a 2-entry in-order FIFO; each entry holds {carry, sum, zero}, and zero is computed from tot_i[N-1:0] at capture.
REQ-015 SHALL define push = valid_i & ready_o and pop = valid_o & ready_i.
REQ-016 SHALL drive ready_o = (occupancy < 2) & ~rst_i from registered occupancy only, with no combinational path from ready_i or valid_i.
REQ-017 SHALL drive valid_o = (occupancy != 0), registered.
REQ-018 SHALL give a latency of one cycle: a push at edge t into an empty FIFO presents the entry with valid_o=1 after edge t.
REQ-019 SHALL hold sum_o, carry_o and zero_o stable while valid_o=1 and ready_i=0.
REQ-020 SHALL drive sum_o, carry_o and zero_o to 0 whenever valid_o=0.
REQ-021 SHALL handle occupancy 1 with push and pop in the same cycle as follows: occupancy stays 1 and the newly pushed entry becomes the head.
REQ-022 SHALL handle occupancy 2 as follows: ready_o=0, valid_i is ignored, and a pop alone drops occupancy to 1 with the second entry becoming the head.
REQ-023 SHALL treat a pop at occupancy 0 as a no-op, so occupancy never underflows.
REQ-024 SHALL keep FIFO pointers 1 bit wide, wrapping modulo 2, and preserve order across wrap.
REQ-025 SHALL increment carry_cnt_o by 1 on a push with tot_i[N]=1.
REQ-026 SHALL saturate carry_cnt_o at 255 with no wrap.
REQ-027 SHALL give clr_cnt_i priority over increment: clear and carry-push in the same cycle leaves carry_cnt_o at 0.
REQ-028 SHALL make all outputs synchronous, with the exceptions of the ready_o reset gating and the output zeroing.

Reset
REQ-029 SHALL, on rst_i=1 at a clock edge, set occupancy to 0, both pointers to 0, valid_o to 0 and carry_cnt_o to 0.
REQ-030 SHALL hold ready_o at 0 while rst_i=1 and drive it to 1 on the first cycle after rst_i falls.
REQ-031 SHALL, when reset occurs mid-operation, discard all stored entries with no pop reported.
REQ-032 SHALL ignore any push attempted in a cycle with rst_i=1.

Verification
REQ-033 SHALL cover basic capture: N=4, push tot_i=5'b1_0011 with ready_i=1 -> next cycle valid_o=1, sum_o=4'h3, carry_o=1, zero_o=0, and carry_cnt_o=1.
REQ-034 SHALL cover the zero flag: push tot_i=5'b1_0000 -> zero_o=1, carry_o=1.
REQ-035 SHALL cover backpressure: ready_i=0 and push A=5'h01, B=5'h02, C=5'h03 on consecutive cycles -> ready_o=0 after B, C is not accepted, A is held stable; then ready_i=1 -> outputs A, then B, then valid_o=0.
REQ-036 SHALL cover simultaneous push/pop at occupancy 1: continuous valid_i and ready_i with 10 distinct totals -> one output per cycle, in order, with occupancy never exceeding 1.
REQ-037 SHALL cover saturation and clear: 300 carry pushes -> carry_cnt_o=255; clr_cnt_i together with a carry push -> carry_cnt_o=0.
REQ-038 SHALL cover reset at full: with 2 entries held, assert rst_i for 1 cycle -> valid_o=0, carry_cnt_o=0, ready_o=0 during reset and 1 after.
